// File: rtl/timer_pkg.sv
// Shared register map constants for the timer peripheral; the bus interface
// and sibling peripherals decode against the same offsets and bit indices.
package timer_pkg;

    localparam int DATA_W = 32;

    // Word offsets (byte address bits [3:2])
    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_PRESC = 2'd1,
        REG_LOAD  = 2'd2,
        REG_STAT  = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IE  = 2;

    localparam int STAT_TIF = 0;

    // Apply byte enables: strobed bytes come from new_v, others keep old_v.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [3:0]        strb
    );
        logic [DATA_W-1:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_core.sv
// Prescaler, 32-bit down counter and expiry detection. A LOAD write takes
// priority over a tick in the same cycle, so no decrement or expiry happens then.
module timer_core
    import timer_pkg::*;
#(
    parameter int PRESC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  per,
    input  logic [PRESC_BITS-1:0] presc,
    input  logic [DATA_W-1:0]     load,
    input  logic                  load_wr,
    output logic [DATA_W-1:0]     cnt,
    output logic                  expire,
    output logic                  en_clr
);

    logic [PRESC_BITS-1:0] pcnt;
    logic                  tick;

    assign tick   = en && (pcnt == presc);
    assign expire = tick && (cnt == '0) && !load_wr;
    assign en_clr = expire && !per;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (load_wr) begin
            pcnt <= '0;
            cnt  <= load;
        end else begin
            pcnt <= (!en || tick) ? '0 : pcnt + 1'b1;
            if (tick) begin
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                else if (per)
                    cnt <= load;
                // one-shot expiry: counter stays at 0, EN is cleared upstream
            end
        end
    end

endmodule

// File: rtl/timer_periph.sv
// Register-mapped down-counting timer: register bank, write/read strobe
// handshakes and level interrupt around timer_core.
module timer_periph
    import timer_pkg::*;
#(
    parameter int PRESC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wr_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic        wr_ack,
    input  logic [3:0]  rd_addr,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_ack,
    output logic        irq
);

    logic                  wr_fire, rd_fire;
    reg_sel_e              wsel, rsel;
    logic                  ctrl_en, ctrl_per, ctrl_ie, tif;
    logic [PRESC_BITS-1:0] presc;
    logic [DATA_W-1:0]     load, load_d, cnt;
    logic [DATA_W-1:0]     presc_ext, presc_merged, rd_mux;
    logic                  ctrl_wr, presc_wr, load_wr, tif_w1c;
    logic                  expire, en_clr;
    logic                  unused_bits;

    // Handshake: one access per enable assertion, acked the following cycle
    assign wr_fire = wr_en && !wr_ack;
    assign rd_fire = rd_en && !rd_ack;

    assign wsel = reg_sel_e'(wr_addr[3:2]);
    assign rsel = reg_sel_e'(rd_addr[3:2]);

    assign ctrl_wr  = wr_fire && (wsel == REG_CTRL) && wr_strb[0];
    assign presc_wr = wr_fire && (wsel == REG_PRESC);
    assign load_wr  = wr_fire && (wsel == REG_LOAD);
    assign tif_w1c  = wr_fire && (wsel == REG_STAT) && wr_strb[0] && wr_data[STAT_TIF];

    always_comb begin
        presc_ext                   = '0;
        presc_ext[PRESC_BITS-1:0]   = presc;
    end

    assign presc_merged = byte_merge(presc_ext, wr_data, wr_strb);
    // Counter reload on a LOAD write sees the strobe-merged value
    assign load_d       = load_wr ? byte_merge(load, wr_data, wr_strb) : load;

    always_comb begin
        rd_mux = '0;
        case (rsel)
            REG_CTRL: begin
                rd_mux[CTRL_EN]  = ctrl_en;
                rd_mux[CTRL_PER] = ctrl_per;
                rd_mux[CTRL_IE]  = ctrl_ie;
            end
            REG_PRESC: rd_mux = presc_ext;
            REG_LOAD:  rd_mux = cnt;
            REG_STAT:  rd_mux[STAT_TIF] = tif;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack   <= 1'b0;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
            ctrl_en  <= 1'b0;
            ctrl_per <= 1'b0;
            ctrl_ie  <= 1'b0;
            presc    <= '0;
            load     <= '0;
            tif      <= 1'b0;
        end else begin
            wr_ack  <= wr_fire;
            rd_ack  <= rd_fire;
            rd_data <= rd_fire ? rd_mux : '0;

            // Written EN overrides a same-cycle one-shot auto-clear
            if (en_clr)
                ctrl_en <= 1'b0;
            if (ctrl_wr) begin
                ctrl_en  <= wr_data[CTRL_EN];
                ctrl_per <= wr_data[CTRL_PER];
                ctrl_ie  <= wr_data[CTRL_IE];
            end

            if (presc_wr)
                presc <= presc_merged[PRESC_BITS-1:0];
            if (load_wr)
                load <= load_d;

            // Hardware set wins over software clear
            if (expire)
                tif <= 1'b1;
            else if (tif_w1c)
                tif <= 1'b0;
        end
    end

    assign irq = tif && ctrl_ie;

    timer_core #(
        .PRESC_BITS(PRESC_BITS)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (ctrl_en),
        .per    (ctrl_per),
        .presc  (presc),
        .load   (load_d),
        .load_wr(load_wr),
        .cnt    (cnt),
        .expire (expire),
        .en_clr (en_clr)
    );

    assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], presc_merged};

endmodule

// File: doc/timer_periph.md
Name: timer_periph

Overview:
- Register-mapped down-counting timer peripheral.
- Sits directly downstream of the AXI4-Lite slave interface block and consumes its register write/read strobe interface (wr_*/rd_*).
- Provides four 32-bit registers, a 16-bit prescaler, one-shot and periodic modes, and a level interrupt to the interrupt controller.

Parameters:
- PRESC_BITS, 16, width of the prescaler register and prescaler counter (1..32).

Ports:
- clk  input  1  system clock
- rst  input  1  active-high synchronous reset
- wr_addr  input  4  register write byte address; bits [3:2] select the word
- wr_en  input  1  write enable; held high until wr_ack
- wr_data  input  32  write data
- wr_strb  input  4  byte enables
- wr_ack  output  1  write acknowledge, single-cycle pulse
- rd_addr  input  4  register read byte address; bits [3:2] select the word
- rd_en  input  1  read enable; held high until rd_ack
- rd_data  output  32  read data, valid while rd_ack=1
- rd_ack  output  1  read acknowledge, single-cycle pulse
- irq  output  1  interrupt request, active high, level

Behaviour:
- Reset values: all registers 0, counter 0, prescaler counter 0, wr_ack 0, rd_ack 0, rd_data 0, irq 0. A reset mid-operation aborts any pending access; no ack is issued for it.
- Register map (address bits [1:0] are ignored):
  - 0x0 CTRL: bit0 EN, bit1 PER (1 = periodic, 0 = one-shot), bit2 IE. Bits [31:3] read 0.
  - 0x4 PRESC: bits [PRESC_BITS-1:0] hold the divide value minus 1. Upper bits read 0.
  - 0x8 LOAD/CNT: a write updates LOAD and, in the same cycle, copies the new LOAD into the counter and zeroes the prescaler counter. A read returns the live counter value.
  - 0xC STAT: bit0 TIF, write-1-to-clear. Other bits read 0 and ignore writes.
- Write handshake:
  - The write executes in the cycle with wr_en=1 and wr_ack=0.
  - wr_ack is registered as wr_en & ~wr_ack, giving exactly one ack pulse one cycle later.
  - A wr_en held for N cycles therefore causes exactly one write.
- Byte strobes: wr_strb[k] gates byte k of each register.
  - CTRL and STAT use byte 0 only.
  - PRESC uses bytes covering PRESC_BITS.
  - For LOAD, the counter reload uses the merged (strobe-applied) LOAD value.
- Read handshake:
  - On rd_en=1 and rd_ack=0, register rd_data from the mux and set rd_ack=1 for one cycle.
  - rd_data returns to 0 in the cycle after the ack.
  - Read latency is 1 cycle.
- Reads have no side effects; in particular, reading STAT does not clear TIF.
- A simultaneous write and read is legal: both are served independently in the same cycle. A read sees the pre-write value.
- Counting:
  - While EN=1, the prescaler counter increments each clk.
  - When it equals PRESC, it wraps to 0 and generates a tick.
  - PRESC=0 gives a tick every cycle.
  - While EN=0, the prescaler counter is held at 0 and the counter is frozen.
- On each tick:
  - If counter ≠ 0: decrement the counter.
  - If counter = 0: set TIF. With PER=1, reload the counter from LOAD. With PER=0, clear EN and hold the counter at 0.
- Event period is (LOAD+1)*(PRESC+1) cycles.
- Simultaneous events:
  - A TIF set in the same cycle as a W1C of TIF: set wins, TIF stays 1.
  - A CTRL write in the same cycle as a one-shot EN auto-clear: the written EN value wins.
  - A LOAD write in the same cycle as a tick: the LOAD write wins, no decrement that cycle.
- irq = TIF & IE, driven from registers with no combinational path from inputs.

Decomposition:
- Shared package holds:
  - register word offsets: CTRL=0, PRESC=1, LOAD=2, STAT=3;
  - CTRL bit indices: EN=0, PER=1, IE=2;
  - STAT bit index: TIF=0.
- The AXI interface and other peripherals reuse these constants.
- One sub-module is natural: timer_core (prescaler, down counter, tick/expiry logic). Its inputs are en, per, presc, load, load_wr; its outputs are cnt, expire, en_clr.
- The register bank and handshake logic stay in timer_periph.

Test Plan:
- Reset, then read 0x0, 0x4, 0x8, 0xC -> each rd_ack pulses once, 1 cycle after rd_en; rd_data=0 each time; irq=0.
- Hold wr_en 3 cycles at 0x8 with data 0x12345678, strb=4'b0101 -> exactly one wr_ack; readback of 0x8 = 0x00340078.
- PRESC=3, LOAD=4, CTRL=0x7 (EN, PER, IE) -> TIF and irq rise every 20 cycles; the counter reads 4..0 and then reloads to 4.
- One-shot: PRESC=0, LOAD=2, CTRL=0x5 -> TIF=1 three cycles after EN; CTRL reads 0x4 (EN cleared); the counter holds 0.
- Write STAT=0x1 in the exact cycle TIF is set -> TIF stays 1. A later STAT=0x1 write -> TIF=0 and irq=0 the next cycle.
- Assert rst while wr_en is high and in the middle of counting -> no wr_ack; all registers, irq and rd_data return to 0.
